// File: rtl/mario_sprite_draw.sv
// rtl/mario_sprite_draw.sv - Mario sprite renderer: per-frame latched position/pose,
// two-stage pixel pipeline (hit/address, then ROM colour keying).
module mario_sprite_draw #(
  parameter int          SPR_W      = 21,
  parameter int          SPR_H      = 41,
  parameter logic [11:0] KEY_COLOR  = 12'h808,
  parameter int          RUN_PERIOD = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  mario_x,
  input  logic [9:0]  mario_y,
  input  logic        face_left,
  input  logic [1:0]  pose,
  input  logic [11:0] rom_color,
  output logic [9:0]  read_address,
  output logic [1:0]  sprite_sel,
  output logic        out_valid,
  output logic        mario_on,
  output logic [11:0] mario_color
);

  localparam int CW = (RUN_PERIOD > 1) ? $clog2(RUN_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RUN_PERIOD - 1);

  localparam logic [1:0] POSE_RUN  = 2'd1;
  localparam logic [1:0] POSE_JUMP = 2'd2;

  logic [9:0]    frame_x;
  logic [9:0]    frame_y;
  logic          frame_face;
  logic [1:0]    frame_pose;
  logic [CW-1:0] run_cnt;
  logic          run_phase;
  logic [CW-1:0] run_cnt_next;
  logic          run_phase_next;

  // Animation advances only when the pose being latched for the new frame is run.
  always_comb begin
    run_cnt_next   = '0;
    run_phase_next = 1'b0;
    if (pose == POSE_RUN) begin
      if (run_cnt == CNT_LAST) begin
        run_cnt_next   = '0;
        run_phase_next = ~run_phase;
      end else begin
        run_cnt_next   = run_cnt + 1'b1;
        run_phase_next = run_phase;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_x    <= '0;
      frame_y    <= '0;
      frame_face <= 1'b0;
      frame_pose <= 2'd0;
      run_cnt    <= '0;
      run_phase  <= 1'b0;
    end else if (frame_start) begin
      frame_x    <= mario_x;
      frame_y    <= mario_y;
      frame_face <= face_left;
      frame_pose <= pose;
      run_cnt    <= run_cnt_next;
      run_phase  <= run_phase_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sprite_sel <= 2'd0;
    end else begin
      case (frame_pose)
        POSE_RUN:  sprite_sel <= {1'b1, run_phase};
        POSE_JUMP: sprite_sel <= 2'd1;
        default:   sprite_sel <= 2'd0;
      endcase
    end
  end

  // 11-bit bounds so a sprite near the right/bottom edge never wraps back to column 0.
  logic        hit;
  logic [9:0]  col;
  logic [9:0]  row;
  logic [9:0]  col_m;
  logic [19:0] addr_full;
  logic        unused_addr_hi;

  always_comb begin
    hit = ({1'b0, DrawX} >= {1'b0, frame_x}) &&
          ({1'b0, DrawX} <  ({1'b0, frame_x} + 11'(SPR_W))) &&
          ({1'b0, DrawY} >= {1'b0, frame_y}) &&
          ({1'b0, DrawY} <  ({1'b0, frame_y} + 11'(SPR_H)));
    col       = DrawX - frame_x;
    row       = DrawY - frame_y;
    col_m     = frame_face ? (10'(SPR_W - 1) - col) : col;
    addr_full = ({10'd0, row} * 20'(SPR_W)) + {10'd0, col_m};
  end

  assign unused_addr_hi = &{1'b0, addr_full[19:10]};

  logic hit1;
  logic valid1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address <= '0;
      hit1         <= 1'b0;
      valid1       <= 1'b0;
      out_valid    <= 1'b0;
      mario_on     <= 1'b0;
      mario_color  <= 12'h000;
    end else begin
      read_address <= (hit && pix_valid) ? addr_full[9:0] : 10'd0;
      hit1         <= hit && pix_valid;
      valid1       <= pix_valid;
      out_valid    <= valid1;
      mario_on     <= hit1 && (rom_color != KEY_COLOR);
      mario_color  <= (hit1 && (rom_color != KEY_COLOR)) ? rom_color : 12'h000;
    end
  end

endmodule

// File: tb/tb_mario_sprite_draw.sv
// tb/tb_mario_sprite_draw.sv - randomized and directed checks of mario_sprite_draw
// against a coordinate-level reference model and a testbench sprite ROM.
module tb_mario_sprite_draw;

  localparam logic [11:0] KEY = 12'h808;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [9:0]  mario_x = '0;
  logic [9:0]  mario_y = '0;
  logic        face_left = 1'b0;
  logic [1:0]  pose = 2'd0;
  logic [11:0] rom_color;
  logic [9:0]  read_address;
  logic [1:0]  sprite_sel;
  logic        out_valid;
  logic        mario_on;
  logic [11:0] mario_color;

  logic [11:0] rom [0:1023];
  assign rom_color = rom[read_address];

  int checks = 0;
  int failures = 0;

  int m_x, m_y, m_face, m_pose, m_cnt, m_phase;

  mario_sprite_draw dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .mario_x(mario_x), .mario_y(mario_y),
    .face_left(face_left), .pose(pose), .rom_color(rom_color),
    .read_address(read_address), .sprite_sel(sprite_sel), .out_valid(out_valid),
    .mario_on(mario_on), .mario_color(mario_color)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic bit ref_hit(int dx, int dy);
    return dx >= m_x && dx < m_x + 21 && dy >= m_y && dy < m_y + 41;
  endfunction

  function automatic int ref_addr(int dx, int dy);
    int c;
    c = dx - m_x;
    if (m_face != 0) c = 20 - c;
    return (dy - m_y) * 21 + c;
  endfunction

  function automatic int ref_sel();
    if (m_pose == 1) return 2 + m_phase;
    if (m_pose == 2) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_face = 0; m_pose = 0; m_cnt = 0; m_phase = 0;
  endtask

  task automatic latch_frame(int x, int y, int face, int p);
    mario_x = 10'(x); mario_y = 10'(y); face_left = face[0]; pose = 2'(p);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_x = x; m_y = y; m_face = face; m_pose = p;
    if (p == 1) begin
      m_cnt++;
      if (m_cnt == 6) begin m_cnt = 0; m_phase ^= 1; end
    end else begin
      m_cnt = 0; m_phase = 0;
    end
    mario_x = 10'($urandom); mario_y = 10'($urandom);
    face_left = 1'($urandom); pose = 2'($urandom);
    tick();
    tick();
  endtask

  task automatic check_pixel(int dx, int dy, int want_addr, bit want_hit);
    logic [11:0] c;
    bit want_on;
    DrawX = 10'(dx); DrawY = 10'(dy); pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    checks++;
    if (read_address !== 10'(want_addr)) begin
      failures++;
      $display("FAIL pixel_addr (%0d,%0d): got %0d expected %0d", dx, dy, read_address, want_addr);
    end
    c = rom[10'(want_addr)];
    want_on = want_hit && (c != KEY);
    tick();
    checks++;
    if (out_valid !== 1'b1 || mario_on !== want_on || mario_color !== (want_on ? c : 12'h000)) begin
      failures++;
      $display("FAIL pixel_out (%0d,%0d): got v=%0b on=%0b col=%h expected v=1 on=%0b col=%h",
               dx, dy, out_valid, mario_on, mario_color, want_on, want_on ? c : 12'h000);
    end
  endtask

  task automatic check_sel(int want, string name);
    checks++;
    if (sprite_sel !== 2'(want)) begin
      failures++;
      $display("FAIL %s: sprite_sel got %0d expected %0d", name, sprite_sel, want);
    end
  endtask

  task automatic check_zero(string name);
    checks++;
    if (read_address !== 10'd0 || sprite_sel !== 2'd0 || out_valid !== 1'b0 ||
        mario_on !== 1'b0 || mario_color !== 12'h000) begin
      failures++;
      $display("FAIL %s: got addr=%0d sel=%0d v=%0b on=%0b col=%h expected all zero",
               name, read_address, sprite_sel, out_valid, mario_on, mario_color);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    model_reset();
    check_zero("reset_state");
  endtask

  task automatic test_directed();
    rom[0] = 12'hF30; rom[860] = KEY; rom[20] = KEY; rom[21] = 12'hF30;
    latch_frame(100, 200, 0, 0);
    check_pixel(100, 200, 0, 1);
    check_pixel(120, 240, 860, 1);
    check_pixel(121, 240, 0, 0);
    check_pixel(99, 200, 0, 0);
    check_pixel(100, 241, 0, 0);
    latch_frame(100, 200, 1, 0);
    check_pixel(100, 200, 20, 1);
    check_pixel(120, 201, 21, 1);
  endtask

  task automatic test_clip();
    latch_frame(630, 100, 0, 0);
    for (int dx = 0; dx <= 10; dx++) check_pixel(dx, 110, 0, 0);
    for (int dx = 630; dx <= 639; dx++) check_pixel(dx, 110, 10 * 21 + (dx - 630), 1);
  endtask

  task automatic test_run_anim();
    latch_frame(10, 10, 0, 0);
    check_sel(0, "stand_sel");
    for (int k = 1; k <= 12; k++) begin
      latch_frame(10, 10, 0, 1);
      check_sel((k >= 6 && k <= 11) ? 3 : 2, $sformatf("run_frame_%0d", k));
      check_sel(ref_sel(), $sformatf("run_model_%0d", k));
    end
    latch_frame(10, 10, 0, 2);
    check_sel(1, "jump_sel");
    latch_frame(10, 10, 0, 1);
    check_sel(2, "run_restart_sel");
    latch_frame(10, 10, 0, 3);
    check_sel(0, "pose3_sel");
  endtask

  task automatic test_same_cycle();
    latch_frame(50, 50, 0, 0);
    DrawX = 10'd55; DrawY = 10'd52; pix_valid = 1'b1;
    mario_x = 10'd300; mario_y = 10'd300; face_left = 1'b0; pose = 2'd0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0; pix_valid = 1'b0;
    checks++;
    if (read_address !== 10'd47) begin
      failures++;
      $display("FAIL same_cycle_old: got %0d expected 47", read_address);
    end
    m_x = 300; m_y = 300; m_face = 0; m_pose = 0; m_cnt = 0; m_phase = 0;
    tick();
    check_pixel(305, 301, 26, 1);
    check_pixel(55, 52, 0, 0);
  endtask

  task automatic test_back_to_back(int ncyc);
    logic [9:0]  ea;
    logic        eh, ev, e_ov, e_on;
    logic [11:0] e_col;
    ea = '0; eh = 1'b0; ev = 1'b0;
    for (int i = 0; i < ncyc + 2; i++) begin
      int dx, dy;
      bit pv, nh;
      pv = (i < ncyc) && ($urandom_range(0, 3) != 0);
      dx = m_x - 5 + int'($urandom_range(0, 30));
      dy = m_y - 5 + int'($urandom_range(0, 50));
      if (dx < 0) dx = 0;
      if (dy < 0) dy = 0;
      DrawX = 10'(dx); DrawY = 10'(dy); pix_valid = pv;
      mario_x = 10'($urandom); mario_y = 10'($urandom); face_left = 1'($urandom);
      e_ov = ev;
      e_on = eh && (rom[ea] != KEY);
      e_col = e_on ? rom[ea] : 12'h000;
      nh = pv && ref_hit(dx, dy);
      ea = nh ? 10'(ref_addr(dx, dy)) : 10'd0;
      eh = nh; ev = pv;
      tick();
      checks++;
      if (read_address !== ea) begin
        failures++;
        $display("FAIL stream_addr cyc %0d: got %0d expected %0d", i, read_address, ea);
      end
      checks++;
      if (out_valid !== e_ov || mario_on !== e_on || mario_color !== e_col) begin
        failures++;
        $display("FAIL stream_out cyc %0d: got v=%0b on=%0b col=%h expected v=%0b on=%0b col=%h",
                 i, out_valid, mario_on, mario_color, e_ov, e_on, e_col);
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 5; f++) begin
      latch_frame(int'($urandom_range(0, 620)), int'($urandom_range(0, 440)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      check_sel(ref_sel(), $sformatf("rand_frame_sel_%0d", f));
      test_back_to_back(150);
    end
  endtask

  task automatic test_reset_mid();
    rom[87] = 12'h0F0;
    latch_frame(200, 100, 0, 1);
    for (int i = 0; i < 3; i++) begin
      DrawX = 10'(205 + i); DrawY = 10'd110; pix_valid = 1'b1;
      tick();
    end
    Reset = 1'b1; frame_start = 1'b1;
    mario_x = 10'd400; mario_y = 10'd400; pose = 2'd1;
    tick();
    Reset = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    model_reset();
    check_zero("reset_mid_c1");
    tick();
    check_zero("reset_mid_c2");
    tick();
    check_zero("reset_mid_c3");
    check_pixel(3, 4, 87, 1);
    latch_frame(0, 0, 0, 1);
    check_sel(2, "post_reset_run_sel");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    model_reset();
    test_reset();
    test_directed();
    test_clip();
    test_run_anim();
    test_same_cycle();
    test_random_frames();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
